// File: rtl/clause_scan_evaluator.sv
// rtl/clause_scan_evaluator.sv - sequential clause-table scanner reporting unsatisfied clauses
module clause_scan_evaluator #(
   parameter int NSAT    = 3,
   parameter int NCLAUSE = 64,
   parameter int NVAR    = 32,
   parameter int VIDX_W  = (NVAR > 1) ? $clog2(NVAR) : 1,
   parameter int CIDX_W  = (NCLAUSE > 1) ? $clog2(NCLAUSE) : 1,
   parameter int CNT_W   = $clog2(NCLAUSE + 1)
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   start_i,
   input  logic                   early_exit_i,
   input  logic [NVAR-1:0]        assign_i,
   output logic                   cl_rd_en_o,
   output logic [CIDX_W-1:0]      cl_addr_o,
   input  logic [NSAT*VIDX_W-1:0] cl_idx_i,
   input  logic [NSAT-1:0]        cl_neg_i,
   input  logic [NSAT-1:0]        cl_en_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   sat_o,
   output logic [CNT_W-1:0]       unsat_cnt_o,
   output logic [CIDX_W-1:0]      first_broken_o,
   output logic                   broken_vld_o
);

   localparam int AEXT_W = 1 << VIDX_W;
   localparam logic [CIDX_W-1:0] LAST_ADDR = CIDX_W'(NCLAUSE - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t              state, state_nxt;
   logic [CIDX_W-1:0]   addr;
   logic [CIDX_W-1:0]   data_addr;
   logic                data_vld;
   logic                early;
   logic [AEXT_W-1:0]   assign_ext;
   logic                any_true;
   logic                clause_broken;
   logic                eval_broken;

   // Clause evaluation on the RAM data; indices beyond NVAR read a zero-padded assignment.
   always_comb begin
      assign_ext = '0;
      assign_ext[NVAR-1:0] = assign_i;
      any_true = 1'b0;
      for (int k = 0; k < NSAT; k++) begin
         if (cl_en_i[k] && (assign_ext[cl_idx_i[k*VIDX_W +: VIDX_W]] ^ cl_neg_i[k])) begin
            any_true = 1'b1;
         end
      end
      clause_broken = (cl_en_i != '0) && !any_true;
   end

   // Only data belonging to the live scan counts; a fetch issued in the early-exit cycle is dropped.
   assign eval_broken = data_vld && ((state == FETCH) || (state == DRAIN)) && clause_broken;

   assign cl_rd_en_o     = (state == FETCH);
   assign cl_addr_o      = addr;
   assign busy_o         = (state != IDLE);
   assign done_o         = (state == DONE);
   assign sat_o          = (unsat_cnt_o == '0);

   // State register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_i) state_nxt = FETCH;
         FETCH: begin
            if (early && eval_broken) begin
               state_nxt = DONE;
            end else if (addr == LAST_ADDR) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Address generation, data tagging and result accumulation.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         addr           <= '0;
         data_addr      <= '0;
         data_vld       <= 1'b0;
         early          <= 1'b0;
         unsat_cnt_o    <= '0;
         first_broken_o <= '0;
         broken_vld_o   <= 1'b0;
      end else begin
         data_vld  <= cl_rd_en_o;
         data_addr <= addr;
         if ((state == IDLE) && start_i) begin
            addr           <= '0;
            early          <= early_exit_i;
            unsat_cnt_o    <= '0;
            first_broken_o <= '0;
            broken_vld_o   <= 1'b0;
         end else if ((state == FETCH) && (addr != LAST_ADDR)) begin
            addr <= addr + 1'b1;
         end
         if (eval_broken) begin
            unsat_cnt_o <= unsat_cnt_o + 1'b1;
            if (!broken_vld_o) begin
               first_broken_o <= data_addr;
               broken_vld_o   <= 1'b1;
            end
         end
      end
   end

endmodule
